// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector: Moore FSM (IDLE/HUNT/MATCH) with selectable overlap.
// Optional saturating match counter is built only when SEQDET_COUNT_EN is defined.
module seq_detector_param #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             dout,
  output logic             cfg_err,
  output logic [CNT_W-1:0] match_count
);

  typedef enum logic [1:0] {IDLE, HUNT, MATCH} state_t;

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;

  logic [PAT_W-1:0] hist_nxt;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] fill_nxt;
  logic             cfg_ok;
  logic             accept;
  logic             hit;

  // A hit only needs the newest len_q bits of history to line up with the pattern.
  always_comb begin
    cfg_ok   = (pat_len >= LEN_W'(2)) && (pat_len <= FILL_MAX);
    accept   = din_valid && !cfg_load && (state != IDLE);
    hist_nxt = {hist[PAT_W-2:0], din};
    fill_nxt = (fill == FILL_MAX) ? fill : fill + LEN_W'(1);
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    hit = accept && (fill_nxt >= len_q) &&
          ((hist_nxt & len_mask) == (pat_q & len_mask));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      dout    <= 1'b0;
      cfg_err <= 1'b0;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist    <= '0;
      fill    <= '0;
    end else if (cfg_load) begin
      pat_q   <= pattern;
      len_q   <= pat_len;
      ovl_q   <= overlap;
      hist    <= '0;
      fill    <= '0;
      dout    <= 1'b0;
      cfg_err <= !cfg_ok;
      state   <= cfg_ok ? HUNT : IDLE;
    end else if (state != IDLE) begin
      if (accept) begin
        hist <= hist_nxt;
        // Non-overlapping mode restarts the fill so matched bits are never reused.
        fill <= (hit && !ovl_q) ? '0 : fill_nxt;
      end
      state <= hit ? MATCH : HUNT;
      dout  <= hit;
    end
  end

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign match_count = cnt;
`else
  logic unused_cnt_clr;

  assign match_count    = '0;
  assign unused_cnt_clr = cnt_clr;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (PAT_W=8, CNT_W=2).
// Counter expectations follow whether SEQDET_COUNT_EN is defined for the build.
module tb_seq_detector_param;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int LEN_W = $clog2(PAT_W) + 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             din;
  logic             din_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;
  logic             cnt_clr;
  logic             dout;
  logic             cfg_err;
  logic [CNT_W-1:0] match_count;

  int tests_run    = 0;
  int tests_failed = 0;

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .cfg_load   (cfg_load),
    .pattern    (pattern),
    .pat_len    (pat_len),
    .overlap    (overlap),
    .cnt_clr    (cnt_clr),
    .dout       (dout),
    .cfg_err    (cfg_err),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] exp_cnt(input int v);
`ifdef SEQDET_COUNT_EN
    return CNT_W'(v);
`else
    return (v == 0) ? '0 : '0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic v);
    din       = b;
    din_valid = v;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    pattern   = p;
    pat_len   = l;
    overlap   = o;
    cfg_load  = 1'b1;
    din_valid = 1'b0;
    tick();
    cfg_load  = 1'b0;
  endtask

  task automatic clear_cnt();
    cnt_clr   = 1'b1;
    din_valid = 1'b0;
    tick();
    cnt_clr   = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] seq;
    seq = 4'b1001;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (dout !== 1'b0 || cfg_err !== 1'b0 || match_count !== exp_cnt(0)) begin
      tests_failed++;
      $display("FAIL reset_state: got dout=%b cfg_err=%b cnt=%0d, expected 0/0/0", dout, cfg_err, match_count);
    end
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_bit(seq[3-i], 1'b1);
      tests_run++;
      if (dout !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_no_cfg bit%0d: got dout=%b, expected 0", i, dout);
      end
    end
  endtask

  task automatic test_overlap();
    logic [6:0] seq;
    logic [6:0] exp;
    seq = 7'b1001001;
    exp = 7'b0001001;
    load_cfg(8'b0000_1001, 4'd4, 1'b1);
    tests_run++;
    if (cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovl_cfg_err: got %b, expected 0", cfg_err);
    end
    clear_cnt();
    for (int i = 0; i < 7; i++) begin
      send_bit(seq[6-i], 1'b1);
      tests_run++;
      if (dout !== exp[6-i]) begin
        tests_failed++;
        $display("FAIL ovl_dout bit%0d: got %b, expected %b", i + 1, dout, exp[6-i]);
      end
    end
    tests_run++;
    if (match_count !== exp_cnt(2)) begin
      tests_failed++;
      $display("FAIL ovl_count: got %0d, expected %0d", match_count, exp_cnt(2));
    end
  endtask

  task automatic test_nonoverlap();
    logic [6:0] seq;
    logic [6:0] exp;
    logic [2:0] pre;
    seq = 7'b1001001;
    exp = 7'b0001000;
    pre = 3'b001;
    // Load with a valid '1' in the same cycle: that bit must be dropped.
    pattern   = 8'b0000_1001;
    pat_len   = 4'd4;
    overlap   = 1'b0;
    cfg_load  = 1'b1;
    din       = 1'b1;
    din_valid = 1'b1;
    tick();
    cfg_load  = 1'b0;
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_bit(pre[2-i], 1'b1);
      tests_run++;
      if (dout !== 1'b0) begin
        tests_failed++;
        $display("FAIL cfg_priority bit%0d: got dout=%b, expected 0", i + 1, dout);
      end
    end
    clear_cnt();
    for (int i = 0; i < 7; i++) begin
      send_bit(seq[6-i], 1'b1);
      tests_run++;
      if (dout !== exp[6-i]) begin
        tests_failed++;
        $display("FAIL novl_dout bit%0d: got %b, expected %b", i + 1, dout, exp[6-i]);
      end
    end
    tests_run++;
    if (match_count !== exp_cnt(1)) begin
      tests_failed++;
      $display("FAIL novl_count: got %0d, expected %0d", match_count, exp_cnt(1));
    end
  endtask

  task automatic test_cfg_err();
    logic [7:0] seq;
    logic [7:0] exp;
    load_cfg(8'hFF, 4'd1, 1'b1);
    tests_run++;
    if (cfg_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL len1_cfg_err: got %b, expected 1", cfg_err);
    end
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b1, 1'b1);
      tests_run++;
      if (dout !== 1'b0) begin
        tests_failed++;
        $display("FAIL len1_dout bit%0d: got %b, expected 0", i + 1, dout);
      end
    end
    load_cfg(8'hFF, 4'd9, 1'b1);
    tests_run++;
    if (cfg_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL len9_cfg_err: got %b, expected 1", cfg_err);
    end
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b1, 1'b1);
      tests_run++;
      if (dout !== 1'b0) begin
        tests_failed++;
        $display("FAIL len9_dout bit%0d: got %b, expected 0", i + 1, dout);
      end
    end
    // Full-width pattern is the largest legal length.
    seq = 8'b1011_0011;
    exp = 8'b0000_0001;
    load_cfg(seq, 4'd8, 1'b0);
    tests_run++;
    if (cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL len8_cfg_err: got %b, expected 0", cfg_err);
    end
    for (int i = 0; i < 8; i++) begin
      send_bit(seq[7-i], 1'b1);
      tests_run++;
      if (dout !== exp[7-i]) begin
        tests_failed++;
        $display("FAIL len8_dout bit%0d: got %b, expected %b", i + 1, dout, exp[7-i]);
      end
    end
  endtask

  task automatic test_gaps();
    logic [6:0] bits;
    logic [6:0] vld;
    logic [6:0] exp;
    bits = 7'b1011101;
    vld  = 7'b1100011;
    exp  = 7'b0000001;
    load_cfg(8'b0000_1001, 4'd4, 1'b1);
    clear_cnt();
    for (int i = 0; i < 7; i++) begin
      send_bit(bits[6-i], vld[6-i]);
      tests_run++;
      if (dout !== exp[6-i]) begin
        tests_failed++;
        $display("FAIL gap_dout cyc%0d: got %b, expected %b", i + 1, dout, exp[6-i]);
      end
    end
    send_bit(1'b0, 1'b0);
    tests_run++;
    if (dout !== 1'b0) begin
      tests_failed++;
      $display("FAIL gap_match_exit: got dout=%b, expected 0", dout);
    end
    tests_run++;
    if (match_count !== exp_cnt(1)) begin
      tests_failed++;
      $display("FAIL gap_count: got %0d, expected %0d", match_count, exp_cnt(1));
    end
  endtask

  task automatic test_midreset();
    logic [3:0] seq;
    seq = 4'b1001;
    load_cfg(8'b0000_1001, 4'd4, 1'b1);
    clear_cnt();
    for (int i = 0; i < 4; i++) send_bit(seq[3-i], 1'b1);
    tests_run++;
    if (dout !== 1'b1 || match_count !== exp_cnt(1)) begin
      tests_failed++;
      $display("FAIL prereset_hit: got dout=%b cnt=%0d, expected 1/%0d", dout, match_count, exp_cnt(1));
    end
    for (int i = 0; i < 3; i++) send_bit(seq[3-i], 1'b1);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (dout !== 1'b0 || match_count !== exp_cnt(0)) begin
      tests_failed++;
      $display("FAIL midreset_now: got dout=%b cnt=%0d, expected 0/0", dout, match_count);
    end
    tick();
    reset_n = 1'b1;
    send_bit(1'b1, 1'b1);
    tests_run++;
    if (dout !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_partial: got dout=%b, expected 0", dout);
    end
    for (int i = 0; i < 4; i++) begin
      send_bit(seq[3-i], 1'b1);
      tests_run++;
      if (dout !== 1'b0) begin
        tests_failed++;
        $display("FAIL midreset_nocfg bit%0d: got %b, expected 0", i + 1, dout);
      end
    end
    load_cfg(8'b0000_1001, 4'd4, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(seq[3-i], 1'b1);
    tests_run++;
    if (dout !== 1'b1) begin
      tests_failed++;
      $display("FAIL reload_hit: got dout=%b, expected 1", dout);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (dout !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_dout_clear: got dout=%b, expected 0", dout);
    end
    tick();
    reset_n = 1'b1;
    load_cfg(8'h00, 4'd0, 1'b0);
    tests_run++;
    if (cfg_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL len0_cfg_err: got %b, expected 1", cfg_err);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_cfg_err: got %b, expected 0", cfg_err);
    end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_saturate();
    logic [5:0] exp;
    exp = 6'b011111;
    load_cfg(8'b0000_0011, 4'd2, 1'b1);
    clear_cnt();
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b1, 1'b1);
      tests_run++;
      if (dout !== exp[5-i]) begin
        tests_failed++;
        $display("FAIL b2b_dout bit%0d: got %b, expected %b", i + 1, dout, exp[5-i]);
      end
    end
    tests_run++;
    if (match_count !== exp_cnt(3)) begin
      tests_failed++;
      $display("FAIL sat_count: got %0d, expected %0d", match_count, exp_cnt(3));
    end
    cnt_clr = 1'b1;
    send_bit(1'b1, 1'b1);
    cnt_clr = 1'b0;
    tests_run++;
    if (match_count !== exp_cnt(1) || dout !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_on_hit: got cnt=%0d dout=%b, expected %0d/1", match_count, dout, exp_cnt(1));
    end
    send_bit(1'b1, 1'b1);
    tests_run++;
    if (match_count !== exp_cnt(2)) begin
      tests_failed++;
      $display("FAIL post_clr_count: got %0d, expected %0d", match_count, exp_cnt(2));
    end
    send_bit(1'b0, 1'b1);
    tests_run++;
    if (dout !== 1'b0 || match_count !== exp_cnt(2)) begin
      tests_failed++;
      $display("FAIL miss_hold: got dout=%b cnt=%0d, expected 0/%0d", dout, match_count, exp_cnt(2));
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    cfg_load  = 1'b0;
    pattern   = '0;
    pat_len   = '0;
    overlap   = 1'b0;
    cnt_clr   = 1'b0;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_cfg_err();
    test_gaps();
    test_midreset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
